ex_pipe_ctrl: RTL

EX_PIPE_CTRL -- requirements
Module: ex_pipe_ctrl

---
 rtl/ex_ctrl_pkg.sv | 25 ++
 rtl/ex_fwd_unit.sv | 39 +++
 rtl/ex_pipe_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ex_ctrl_pkg.sv
// Shared types for the EX-stage pipeline controller: FSM states, operand
// forwarding select encodings and the ID-source match helper.
package ex_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        MULTI = 1'b1
    } state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // True when a writer of register rd feeds either used ID source; x0 never matches.
    function automatic logic src_hit(
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic       use_rs1,
        input logic [4:0] rs2,
        input logic       use_rs2
    );
        return (rd != 5'd0) && ((use_rs1 && (rs1 == rd)) || (use_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/ex_fwd_unit.sv
// ALU operand forwarding select: MEM result has priority over WB, x0 never forwards.
module ex_fwd_unit
    import ex_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs1,
    input  logic [4:0] ex_rs2,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_rd,
    input  logic       wb_reg_write,
    input  logic [4:0] wb_rd,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    logic [4:0] rs  [2];
    logic [1:0] sel [2];

    assign rs[0] = ex_rs1;
    assign rs[1] = ex_rs2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            always_comb begin
                sel[gi] = FWD_REG;
                if (rs[gi] != 5'd0) begin
                    if (mem_reg_write && (mem_rd == rs[gi])) begin
                        sel[gi] = FWD_MEM;
                    end else if (wb_reg_write && (wb_rd == rs[gi])) begin
                        sel[gi] = FWD_WB;
                    end
                end
            end
        end
    endgenerate

    assign fwd_a = sel[0];
    assign fwd_b = sel[1];

endmodule

// File: rtl/ex_pipe_ctrl.sv
// EX-stage pipeline controller: load-use/RAW stalls, branch flush, multi-cycle
// op hold and perf counters. Define EX_FWD_EN to enable operand forwarding.
module ex_pipe_ctrl
    import ex_ctrl_pkg::*;
#(
    parameter int MULTI_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic        ex_multi,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic        branch_taken,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        id_ex_bubble,
    output logic        if_id_flush,
    output logic        ex_hold,
    output logic        ex_done,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam logic [3:0] CNT_LOAD = 4'(MULTI_LAT - 1);

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [31:0] stall_cnt_reg, flush_cnt_reg;
    logic        load_use;
    logic        raw_hazard;

    assign load_use = ex_valid && ex_mem_read &&
                      src_hit(ex_rd, id_rs1, id_use_rs1, id_rs2, id_use_rs2);

`ifdef EX_FWD_EN
    logic unused_inputs;
    assign unused_inputs = ex_reg_write;
    assign raw_hazard    = 1'b0;

    ex_fwd_unit u_fwd (
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .mem_reg_write (mem_reg_write),
        .mem_rd        (mem_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_rd         (wb_rd),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b)
    );
`else
    // No bypass paths: any in-flight writer of an ID source must drain first.
    // WB needs no check since the register file writes before it reads.
    logic unused_inputs;
    assign unused_inputs = ^{ex_rs1, ex_rs2, wb_reg_write, wb_rd};
    assign raw_hazard =
        (ex_reg_write  && src_hit(ex_rd,  id_rs1, id_use_rs1, id_rs2, id_use_rs2)) ||
        (mem_reg_write && src_hit(mem_rd, id_rs1, id_use_rs1, id_rs2, id_use_rs2));
    assign fwd_a = FWD_REG;
    assign fwd_b = FWD_REG;
`endif

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        ex_hold      = 1'b0;
        ex_done      = 1'b0;
        case (state_reg)
            RUN: begin
                if (ex_valid && branch_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (load_use || raw_hazard) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                end
                if (ex_valid && ex_multi) begin
                    state_next = MULTI;
                    cnt_next   = CNT_LOAD;
                end
            end
            MULTI: begin
                ex_hold     = 1'b1;
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                if (cnt_reg == 4'd0) begin
                    ex_done    = 1'b1;
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            cnt_reg       <= 4'd0;
            stall_cnt_reg <= 32'd0;
            flush_cnt_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (pc_stall) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (if_id_flush) begin
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_reg;
    assign flush_count  = flush_cnt_reg;

endmodule
